aes_seq_ctrl: RTL and testbench
===============================

Name: aes_seq_ctrl

Overview:
Sequences the receive-side encryption datapath: takes a packed 128-bit block from the data extractor, hands it to the AES controller, waits for completion, and drains the 16 ciphertext bytes into the encrypted-data FIFO one byte per cycle, stalling while the FIFO is full. Sits between the extractor, the AES controller and the encrypted FIFO in the USB encryptor top level. Provides an AES-completion watchdog, a flush for aborted packets, and a completed-block counter.

Parameters:
BLOCK_BYTES, 16, bytes per AES block; fixes the drain count. The width is fixed at 128 bits.
TIMEOUT, 64, maximum cycles spent in WAIT before an error is flagged.

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  reset, synchronous, active-high (asserted = 1, despite the name)
blk_ready  in  1  extractor holds a valid 128-bit block
blk_data  in  128  block from the extractor
blk_ack  out  1  one-cycle pulse: block consumed; extractor may advance
aes_start  out  1  one-cycle start pulse to the AES controller
aes_din  out  128  plaintext to AES; registered; stable from START until the next LOAD
aes_complete  in  1  AES result valid; sampled in WAIT only
aes_dout  in  128  ciphertext from AES
push_en  out  1  write strobe to the encrypted FIFO
push_data  out  8  ciphertext byte, MSB byte first
fifo_full  in  1  encrypted FIFO full
flush  in  1  abort the current block, e.g. on EOP/error
busy  out  1  high in any state except IDLE
timeout_err  out  1  sticky watchdog error
blocks_done  out  16  count of fully drained blocks; wraps

Behaviour:
- Reset (n_rst=1 at a clk edge): state=IDLE; aes_din, the ciphertext register, byte_cnt, timer and blocks_done all cleared; timeout_err=0.
- Reset effect on outputs: blk_ack, aes_start and push_en are 0 in the cycle after the reset edge.
- Priority at each edge: n_rst > flush > normal transitions.
- States and transitions:
  - IDLE: if blk_ready, latch blk_data into aes_din and go to LOAD; otherwise stay.
  - LOAD: blk_ack=1; go to START.
  - START: aes_start=1; timer<=0; go to WAIT.
  - WAIT: if aes_complete, latch aes_dout into the ciphertext register, set byte_cnt<=0 and go to DRAIN.
  - WAIT, no completion: timer increments each cycle; when timer==TIMEOUT-1 without aes_complete, go to ERR.
  - DRAIN: push_en = !fifo_full (combinational); push_data = cipher[127-8*byte_cnt -: 8].
  - DRAIN, per push: each cycle with push_en=1, byte_cnt increments.
  - DRAIN, last byte: on the push with byte_cnt==BLOCK_BYTES-1, increment blocks_done and go to IDLE.
  - DRAIN, FIFO full: while fifo_full=1, push_en=0 and byte_cnt, push_data and state hold. There is no limit on stall length.
  - ERR: timeout_err=1 (sticky); no pushes; stay until flush or n_rst.
- Other output rules: blk_ack, aes_start and push_en are 0 in every state except the one named above. busy = (state != IDLE).
- Latency: blk_ready sampled high at edge N gives blk_ack in cycle N+1, aes_start in N+2, and WAIT from N+3. The first push occurs in the cycle after aes_complete is sampled. The minimum drain is 16 cycles.
- Flush:
  - From any state: next state is IDLE.
  - timeout_err clears; byte_cnt and timer clear.
  - push_en, blk_ack and aes_start are forced 0 in the cycle flush is high.
  - blocks_done is not incremented for the aborted block.
  - Flush while IDLE is a no-op apart from clearing timeout_err.
- Ignored inputs: aes_complete outside WAIT is ignored. blk_ready outside IDLE is ignored; the extractor holds it until blk_ack.
- Simultaneous events:
  - aes_complete in the same cycle the timer reaches TIMEOUT-1: completion wins and the state goes to DRAIN.
  - blk_ready high in the cycle the last byte is pushed: not consumed until the following IDLE cycle, so there is one IDLE bubble per block.
- blocks_done wraps from 0xFFFF to 0x0000 silently.

Test Plan:
- Basic block: after reset, blk_data=0x00112233_44556677_8899AABB_CCDDEEFF with blk_ready=1, and aes_complete 5 cycles after aes_start with aes_dout=0x69C4E0D8_6A7B0430_D8CDB780_70B4C55A -> blk_ack at N+1, aes_start at N+2, aes_din equals blk_data, 16 consecutive pushes 0x69,0xC4,...,0x5A, blocks_done=1, busy falls after the 0x5A push.
- Backpressure: raise fifo_full for 3 cycles after byte 4 -> push_en=0 for exactly those 3 cycles, byte 5 pushed next, total 16 pushes, no byte lost or duplicated.
- Watchdog: TIMEOUT=64, never assert aes_complete -> state ERR after 64 WAIT cycles, timeout_err=1 and held, no pushes; pulse flush -> timeout_err=0, busy=0 next cycle.
- Flush mid-drain: assert flush after 7 bytes -> no further pushes, blocks_done unchanged; the next block drains all 16 bytes from byte 0.
- Reset mid-operation: assert n_rst for 1 cycle in WAIT -> all outputs 0 next cycle, blocks_done=0; a late aes_complete is ignored.
- Back-to-back and wrap: preload by running 65535 blocks (or force the counter) and hold blk_ready continuously -> one IDLE cycle between blocks; blocks_done rolls from 0xFFFF to 0x0000.

Source files
------------

// File: rtl/aes_seq_ctrl.sv
// aes_seq_ctrl: feeds extractor blocks to AES, then drains ciphertext bytes into the encrypted FIFO
module aes_seq_ctrl #(
  parameter int BLOCK_BYTES = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         blk_ready,
  input  logic [127:0] blk_data,
  output logic         blk_ack,
  output logic         aes_start,
  output logic [127:0] aes_din,
  input  logic         aes_complete,
  input  logic [127:0] aes_dout,
  output logic         push_en,
  output logic [7:0]   push_data,
  input  logic         fifo_full,
  input  logic         flush,
  output logic         busy,
  output logic         timeout_err,
  output logic [15:0]  blocks_done
);
  localparam int CW = $clog2(BLOCK_BYTES);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN, ERR} state_t;
  state_t         state_q, state_d;
  logic [127:0]   din_q, din_d, cipher_q, cipher_d, cipher_sh;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [15:0]    done_q, done_d;
  logic           err_q, err_d;
  assign blk_ack     = state_q == LOAD && !flush;
  assign aes_start   = state_q == START && !flush;
  assign push_en     = state_q == DRAIN && !fifo_full && !flush;
  assign cipher_sh   = cipher_q << {cnt_q, 3'b000};
  assign push_data   = cipher_sh[127:120];
  assign aes_din     = din_q;
  assign busy        = state_q != IDLE;
  assign timeout_err = err_q;
  assign blocks_done = done_q;
  always_comb begin
    state_d  = state_q;
    din_d    = din_q;
    cipher_d = cipher_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    done_d   = done_q;
    err_d    = err_q;
    if (flush) begin
      state_d = IDLE;
      err_d   = 1'b0;
      cnt_d   = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: if (blk_ready) begin
          din_d   = blk_data;
          state_d = LOAD;
        end
        LOAD: state_d = START;
        START: begin
          timer_d = '0;
          state_d = WAIT;
        end
        // completion takes precedence over the watchdog expiring in the same cycle
        WAIT: if (aes_complete) begin
          cipher_d = aes_dout;
          cnt_d    = '0;
          state_d  = DRAIN;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else timer_d = timer_q + 1'b1;
        DRAIN: if (!fifo_full) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(BLOCK_BYTES - 1)) begin
            done_d  = done_q + 16'd1;
            state_d = IDLE;
          end
        end
        ERR: state_d = ERR;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q  <= IDLE;
      din_q    <= '0;
      cipher_q <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      cipher_q <= cipher_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_aes_seq_ctrl.sv
// tb_aes_seq_ctrl: scoreboard bench for aes_seq_ctrl; expected FIFO bytes queued at completion, popped by a monitor
module tb_aes_seq_ctrl;
  logic         clk = 0, n_rst = 1, blk_ready = 0, aes_complete = 0, fifo_full = 0, flush = 0;
  logic [127:0] blk_data = '0, aes_dout = '0, aes_din;
  logic         blk_ack, aes_start, push_en, busy, timeout_err;
  logic [7:0]   push_data;
  logic [15:0]  blocks_done;
  logic [7:0]   exp_q[$];
  int           checks = 0, errors = 0, pushes = 0;
  localparam logic [127:0] P0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] C0 = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
  localparam logic [127:0] C1 = 128'h0102030405060708090A0B0C0D0E0F10;
  localparam logic [127:0] C2 = 128'hF0E0D0C0B0A090807060504030201000;
  localparam logic [127:0] C3 = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;

  aes_seq_ctrl dut (
    .clk(clk), .n_rst(n_rst), .blk_ready(blk_ready), .blk_data(blk_data), .blk_ack(blk_ack),
    .aes_start(aes_start), .aes_din(aes_din), .aes_complete(aes_complete), .aes_dout(aes_dout),
    .push_en(push_en), .push_data(push_data), .fifo_full(fifo_full), .flush(flush), .busy(busy),
    .timeout_err(timeout_err), .blocks_done(blocks_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (push_en) begin
    checks++;
    pushes++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL push_unexpected: got %h, no byte expected", push_data);
    end else begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (push_data !== e) begin
        errors++;
        $display("FAIL push_byte: got %h expected %h", push_data, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_block(input logic [127:0] c);
    logic [127:0] t;
    t = c;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(t[127:120]);
      t = t << 8;
    end
  endtask

  task automatic start_block(input logic [127:0] d);
    blk_ready = 1;
    blk_data  = d;
    tick();
    check("blk_ack", {127'd0, blk_ack}, 128'd1);
    check("aes_din", aes_din, d);
    blk_ready = 0;
    tick();
    check("aes_start", {127'd0, aes_start}, 128'd1);
    check("blk_ack_pulse", {127'd0, blk_ack}, 128'd0);
    tick();
    check("wait_busy", {127'd0, busy}, 128'd1);
  endtask

  task automatic complete(input logic [127:0] c);
    expect_block(c);
    aes_dout     = c;
    aes_complete = 1;
    tick();
    aes_complete = 0;
    check("first_push_en", {127'd0, push_en}, 128'd1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    check("drain_done_idle", {127'd0, busy}, 128'd0);
  endtask

  initial begin
    int base, n, idle_cnt;
    tick();
    tick();
    check("rst_blk_ack", {127'd0, blk_ack}, 128'd0);
    check("rst_aes_start", {127'd0, aes_start}, 128'd0);
    check("rst_push_en", {127'd0, push_en}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_blocks_done", {112'd0, blocks_done}, 128'd0);
    check("rst_aes_din", aes_din, 128'd0);
    n_rst = 0;
    tick();
    // basic block, completion 5 cycles after aes_start
    base = pushes;
    start_block(P0);
    repeat (4) tick();
    complete(C0);
    check("first_byte", {120'd0, push_data}, 128'h69);
    wait_idle(40);
    check("basic_pushes", pushes - base, 16);
    check("basic_done", {112'd0, blocks_done}, 128'd1);
    check("basic_queue", exp_q.size(), 0);
    // backpressure after byte 4
    base = pushes;
    start_block(128'h1);
    complete(C1);
    n = 0;
    while (pushes - base < 4 && n < 40) begin
      tick();
      n++;
    end
    fifo_full = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_push_en", {127'd0, push_en}, 128'd0);
      tick();
    end
    fifo_full = 0;
    wait_idle(40);
    check("bp_pushes", pushes - base, 16);
    check("bp_done", {112'd0, blocks_done}, 128'd2);
    check("bp_queue", exp_q.size(), 0);
    // watchdog
    base = pushes;
    start_block(128'h2);
    repeat (63) tick();
    check("wd_before_err", {127'd0, timeout_err}, 128'd0);
    tick();
    check("wd_err", {127'd0, timeout_err}, 128'd1);
    repeat (3) tick();
    check("wd_err_sticky", {127'd0, timeout_err}, 128'd1);
    check("wd_busy", {127'd0, busy}, 128'd1);
    flush = 1;
    tick();
    flush = 0;
    check("wd_flush_err", {127'd0, timeout_err}, 128'd0);
    check("wd_flush_busy", {127'd0, busy}, 128'd0);
    check("wd_no_pushes", pushes - base, 0);
    // flush mid-drain after 7 bytes
    base = pushes;
    start_block(128'h3);
    complete(C2);
    n = 0;
    while (pushes - base < 7 && n < 40) begin
      tick();
      n++;
    end
    flush = 1;
    #1;
    check("flush_push_en", {127'd0, push_en}, 128'd0);
    tick();
    flush = 0;
    exp_q.delete();
    check("flush_pushes", pushes - base, 7);
    check("flush_idle", {127'd0, busy}, 128'd0);
    check("flush_done", {112'd0, blocks_done}, 128'd2);
    base = pushes;
    start_block(128'h4);
    complete(C3);
    check("restart_byte0", {120'd0, push_data}, 128'hDE);
    wait_idle(40);
    check("restart_pushes", pushes - base, 16);
    check("restart_done", {112'd0, blocks_done}, 128'd3);
    // reset while waiting
    start_block(128'h5);
    repeat (2) tick();
    n_rst = 1;
    tick();
    n_rst = 0;
    check("mid_rst_busy", {127'd0, busy}, 128'd0);
    check("mid_rst_outs", {125'd0, blk_ack, aes_start, push_en}, 128'd0);
    check("mid_rst_done", {112'd0, blocks_done}, 128'd0);
    check("mid_rst_din", aes_din, 128'd0);
    aes_dout     = C1;
    aes_complete = 1;
    tick();
    aes_complete = 0;
    check("late_complete_idle", {127'd0, busy}, 128'd0);
    // back-to-back across counter wrap
    force dut.done_q = 16'hFFFE;
    tick();
    release dut.done_q;
    check("preload", {112'd0, blocks_done}, 128'hFFFE);
    expect_block(C0);
    expect_block(C0);
    aes_dout     = C0;
    blk_data     = P0;
    blk_ready    = 1;
    aes_complete = 1;
    idle_cnt     = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k < 40 && !busy) idle_cnt++;
      if (k == 20) begin
        check("b2b_idle1", {127'd0, busy}, 128'd0);
        check("b2b_ffff", {112'd0, blocks_done}, 128'hFFFF);
      end
      if (k == 40) begin
        blk_ready    = 0;
        aes_complete = 0;
        check("b2b_idle2", {127'd0, busy}, 128'd0);
        check("b2b_wrap", {112'd0, blocks_done}, 128'd0);
      end
    end
    check("b2b_bubbles", idle_cnt, 1);
    check("b2b_queue", exp_q.size(), 0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not complete, limit reached");
    $fatal(1);
  end
endmodule
